// File: rtl/uart_tx_core.sv
// uart_tx_core
// 8N1 UART serializer. A byte presented on tx_data is accepted when send_en
// is high while idle, then shifted out on txd as start bit, eight data bits
// (LSB first) and a stop bit. Each bit slot lasts N clocks, where N is picked
// from a fixed divisor table by baud_set at acceptance. Used as the host
// serial-link emulator feeding the OFDM modulator's serial input.
//
// Ports:
//   clk       system clock (50 MHz), rising edge
//   reset     synchronous, active-high reset
//   baud_set  baud select: 0..4 -> 115200/57600/38400/19200/9600, 5..7 -> 115200
//   send_en   level request; a frame starts when high while idle
//   tx_data   byte to send, sampled only at frame acceptance
//   txd       registered serial output, idle high
//   tx_done   registered one-clock pulse in the idle clock after each frame

module uart_tx_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DIV_115200 = 434,
  parameter int DIV_57600  = 868,
  parameter int DIV_38400  = 1302,
  parameter int DIV_19200  = 2604,
  parameter int DIV_9600   = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_set,
  input  logic       send_en,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_done
);

  // The divisor table is written for a 50 MHz clock; CLK_HZ only documents that.
  if (CLK_HZ < 1) begin : g_clk_check
    $error("uart_tx_core: CLK_HZ must be positive");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [12:0] div_sel;
  logic [12:0] div_lat;
  logic [12:0] div_cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  shreg;

  always_comb begin
    div_sel = 13'(DIV_115200);
    case (baud_set)
      3'd1:    div_sel = 13'(DIV_57600);
      3'd2:    div_sel = 13'(DIV_38400);
      3'd3:    div_sel = 13'(DIV_19200);
      3'd4:    div_sel = 13'(DIV_9600);
      default: div_sel = 13'(DIV_115200);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      tx_done <= 1'b0;
      div_lat <= '0;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (send_en) begin
            // Start bit goes out on the acceptance edge itself.
            state   <= SEND;
            shreg   <= tx_data;
            div_lat <= div_sel;
            div_cnt <= '0;
            bit_idx <= '0;
            txd     <= 1'b0;
          end
        end
        SEND: begin
          if (div_cnt == div_lat - 13'd1) begin
            div_cnt <= '0;
            if (bit_idx == 4'd9) begin
              // Stop bit finished; the following idle clock carries tx_done
              // and may already accept the next frame.
              state   <= IDLE;
              tx_done <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == 4'd8) begin
                txd <= 1'b1;
              end else begin
                txd   <= shreg[0];
                shreg <= {1'b0, shreg[7:1]};
              end
            end
          end else begin
            div_cnt <= div_cnt + 13'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core. The driver pushes one expected frame record per
// request into a queue; a monitor detects each start bit on txd, pops the
// record and checks every clock of the frame against a slot model
// (slot = clock / N), the bit-centre decode, tx_done timing and frame spacing.
module tb_uart_tx_core;

  typedef struct {
    logic [7:0] data;
    int         n;
    int         exp_start;  // expected start cycle, -1 = unchecked
    int         gap;        // expected spacing from previous start, 0 = unchecked
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_set = 3'd0;
  logic       send_en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       txd;
  logic       tx_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int idle_err = 0;

  frame_t exp_q[$];
  frame_t cur;
  bit     in_frame = 1'b0;
  bit     reset_edge = 1'b0;
  bit     stray_seen = 1'b0;
  int     k = 0;
  int     bit_err = 0;
  int     last_start = 0;
  logic [7:0] dec;

  uart_tx_core dut (
    .clk      (clk),
    .reset    (reset),
    .baud_set (baud_set),
    .send_en  (send_en),
    .tx_data  (tx_data),
    .txd      (txd),
    .tx_done  (tx_done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    reset_edge <= reset;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int div_of(int bs);
    case (bs)
      1: return 868;
      2: return 1302;
      3: return 2604;
      4: return 5208;
      default: return 434;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    int s;
    logic expb;
    if (reset_edge) begin
      if (in_frame) begin
        check("abort_txd", txd, 1);
        check("abort_done", tx_done, 0);
        in_frame = 1'b0;
      end else if (txd !== 1'b1 || tx_done !== 1'b0) begin
        idle_err++;
      end
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          if (!stray_seen) begin
            stray_seen = 1'b1;
            check("stray_start", 1, 0);
          end
        end else begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          k = 0;
          bit_err = 0;
          dec = 8'h00;
          if (cur.exp_start >= 0) check("start_latency", cyc, cur.exp_start);
          if (cur.gap > 0) check("start_gap", cyc - last_start, cur.gap);
          last_start = cyc;
          if (tx_done !== 1'b0) bit_err++;
        end
      end else if (txd !== 1'b1 || tx_done !== 1'b0) begin
        idle_err++;
      end
    end else begin
      k++;
      if (k == 10 * cur.n) begin
        check("done_pulse", tx_done, 1);
        check("end_txd", txd, 1);
        check("frame_bits", bit_err, 0);
        check("decode", dec, cur.data);
        in_frame = 1'b0;
      end else begin
        s = k / cur.n;
        if (s == 0) expb = 1'b0;
        else if (s == 9) expb = 1'b1;
        else expb = cur.data[s-1];
        if (txd !== expb || tx_done !== 1'b0) bit_err++;
        if (s >= 1 && s <= 8 && (k % cur.n) == cur.n / 2) dec[s-1] = txd;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !in_frame) break;
    end
    #1;
    if (i >= max_cyc) check("timeout", 0, 1);
  endtask

  task automatic push(logic [7:0] d, int bs, int st, int gap);
    frame_t f;
    f.data = d;
    f.n = div_of(bs);
    f.exp_start = st;
    f.gap = gap;
    exp_q.push_back(f);
  endtask

  task automatic pulse_frame(logic [7:0] d, logic [2:0] bs, int budget);
    tx_data = d;
    baud_set = bs;
    push(d, int'(bs), cyc + 1, 0);
    send_en = 1'b1;
    tick(1);
    send_en = 1'b0;
    wait_idle(budget);
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] bs;
    // Reset held with send_en high: output must stay idle.
    tick(10);
    check("rst_txd", txd, 1);
    check("rst_done", tx_done, 0);
    d = 8'($urandom);
    tx_data = d;
    push(d, 0, cyc + 1, 0);
    reset = 1'b0;
    tick(1);
    send_en = 1'b0;
    wait_idle(5000);

    // Single frame 0x99 at 115200.
    pulse_frame(8'h99, 3'd0, 5000);

    // Back-to-back with mid-frame input changes.
    tx_data = 8'h66;
    baud_set = 3'd0;
    push(8'h66, 0, cyc + 1, 0);
    push(8'h00, 0, -1, 4341);
    send_en = 1'b1;
    tick(1);
    tick(2000);
    tx_data = 8'h00;
    tick(4341);
    send_en = 1'b0;
    baud_set = 3'd4;
    tx_data = 8'hFF;
    wait_idle(5000);

    // 9600 baud.
    pulse_frame(8'hA5, 3'd4, 53000);

    // Out-of-range select maps to 115200.
    pulse_frame(8'($urandom), 3'd6, 5000);

    // Reset during data bit 3 aborts; a fresh frame follows.
    d = 8'($urandom);
    tx_data = d;
    baud_set = 3'd0;
    push(d, 0, cyc + 1, 0);
    send_en = 1'b1;
    tick(1);
    send_en = 1'b0;
    tick(4 * 434 + 200);
    reset = 1'b1;
    tick(1);
    send_en = 1'b1;
    d = 8'($urandom);
    tx_data = d;
    tick(1);
    push(d, 0, cyc + 1, 0);
    reset = 1'b0;
    tick(1);
    send_en = 1'b0;
    wait_idle(5000);

    // Random frames at the fast rates.
    for (int r = 0; r < 2; r++) begin
      case ($urandom_range(0, 2))
        0: bs = 3'd0;
        1: bs = 3'd5;
        default: bs = 3'd7;
      endcase
      pulse_frame(8'($urandom), bs, 5000);
    end

    tick(20);
    check("idle_line", idle_err, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
